// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: streams a NUM_OF_WORDS-word message out of word-addressed RAM and
// hands the compressor fully padded 512-bit blocks over a valid/ready handshake.
module sha256_msg_padder #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  message_addr,
    output logic         mem_clk,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    input  logic [31:0]  mem_read_data,
    output logic         block_valid,
    input  logic         block_ready,
    output logic [511:0] block_data,
    output logic         block_last,
    output logic         done
);

    // Delimiter word plus the two length words must fit after the message.
    function automatic int calc_num_blocks(input int n_words);
        return (n_words + 32'sd18) / 32'sd16;
    endfunction

    localparam int          NUM_BLOCKS = calc_num_blocks(NUM_OF_WORDS);
    localparam logic [31:0] N_WORDS    = 32'(NUM_OF_WORDS);
    localparam logic [31:0] LAST_BLK   = 32'(NUM_BLOCKS - 1);
    localparam logic [63:0] MSG_BITS   = 64'(NUM_OF_WORDS) * 64'd32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        PAD     = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t             state_r;
    logic [15:0]        blk_r;
    logic [31:0]        rd_idx_r;
    logic [31:0]        wr_idx_r;
    logic [15:0]        base_r;
    logic [15:0]        mem_addr_r;
    logic               cap_r;
    logic [0:15][31:0]  words_r;
    logic               block_valid_r;
    logic               block_last_r;
    logic               done_r;

    logic [31:0]        blk_base_s;
    logic [31:0]        blk_end_s;
    logic [31:0]        rd_end_s;
    logic               issue_s;
    logic               last_cap_s;
    logic               is_last_s;
    logic [0:15][31:0]  pad_s;

    assign mem_clk     = clk;
    assign mem_we      = 1'b0;
    assign mem_addr    = mem_addr_r;
    assign block_valid = block_valid_r;
    assign block_data  = words_r;
    assign block_last  = block_last_r;
    assign done        = done_r;

    // Block bounds, read/capture pacing and the padded image of the current block.
    always_comb begin
        blk_base_s = {16'd0, blk_r} * 32'd16;
        blk_end_s  = blk_base_s + 32'd16;
        if (blk_end_s < N_WORDS) begin
            rd_end_s = blk_end_s;
        end else begin
            rd_end_s = N_WORDS;
        end
        issue_s    = (rd_idx_r < rd_end_s);
        last_cap_s = cap_r && ((wr_idx_r + 32'd1) == rd_end_s);
        is_last_s  = ({16'd0, blk_r} == LAST_BLK);
        pad_s      = 512'd0;
        for (int j = 0; j < 16; j++) begin
            if ((blk_base_s + 32'(j)) < N_WORDS) begin
                pad_s[j] = words_r[j];
            end else if ((blk_base_s + 32'(j)) == N_WORDS) begin
                pad_s[j] = 32'h8000_0000;
            end else if (is_last_s && (j == 14)) begin
                pad_s[j] = MSG_BITS[63:32];
            end else if (is_last_s && (j == 15)) begin
                pad_s[j] = MSG_BITS[31:0];
            end else begin
                pad_s[j] = 32'd0;
            end
        end
    end

    // Control FSM: fetch message words, pad, present, and signal completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            blk_r         <= 16'd0;
            rd_idx_r      <= 32'd0;
            wr_idx_r      <= 32'd0;
            base_r        <= 16'd0;
            mem_addr_r    <= 16'd0;
            cap_r         <= 1'b0;
            words_r       <= 512'd0;
            block_valid_r <= 1'b0;
            block_last_r  <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r    <= FETCH;
                        blk_r      <= 16'd0;
                        rd_idx_r   <= 32'd0;
                        wr_idx_r   <= 32'd0;
                        base_r     <= message_addr;
                        mem_addr_r <= message_addr;
                        cap_r      <= 1'b0;
                    end
                end
                FETCH: begin
                    // mem_addr always tracks base + rd_idx; cap_r marks data due next cycle.
                    if (issue_s) begin
                        rd_idx_r   <= rd_idx_r + 32'd1;
                        mem_addr_r <= base_r + rd_idx_r[15:0] + 16'd1;
                        cap_r      <= 1'b1;
                    end else begin
                        cap_r <= 1'b0;
                    end
                    if (cap_r) begin
                        words_r[wr_idx_r[3:0]] <= mem_read_data;
                        wr_idx_r               <= wr_idx_r + 32'd1;
                        if (last_cap_s) begin
                            state_r    <= PAD;
                            mem_addr_r <= 16'd0;
                            cap_r      <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    words_r       <= pad_s;
                    block_valid_r <= 1'b1;
                    block_last_r  <= is_last_s;
                    state_r       <= PRESENT;
                end
                PRESENT: begin
                    if (block_ready) begin
                        block_valid_r <= 1'b0;
                        block_last_r  <= 1'b0;
                        if (is_last_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            blk_r <= blk_r + 16'd1;
                            // Blocks holding only padding skip the memory entirely.
                            if (blk_end_s < N_WORDS) begin
                                state_r    <= FETCH;
                                mem_addr_r <= base_r + rd_idx_r[15:0];
                                cap_r      <= 1'b0;
                            end else begin
                                state_r <= PAD;
                            end
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: four instances (N=20,13,14,16) share one RAM model;
// expected blocks come from a word-stream padding model and are checked by a separate monitor.
module tb_sha256_msg_padder;

    localparam int NI = 4;
    localparam int NW [NI] = '{20, 13, 14, 16};

    typedef struct {
        int           inst;
        logic [511:0] data;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]         rst_v;
    logic [NI-1:0]         start_v;
    logic [NI-1:0]         brdy_v;
    logic [NI-1:0][15:0]   addr_v;
    wire  [NI-1:0]         mem_clk_v;
    wire  [NI-1:0]         mem_we_v;
    wire  [NI-1:0][15:0]   maddr_v;
    wire  [NI-1:0]         bv_v;
    wire  [NI-1:0][511:0]  bd_v;
    wire  [NI-1:0]         bl_v;
    wire  [NI-1:0]         done_v;

    logic [31:0] mem [0:65535];
    exp_t        exp_q [$];
    int          compared   = 0;
    int          mismatched = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [31:0] rdata;
        always @(posedge clk) rdata <= mem[maddr_v[g]];
        sha256_msg_padder #(.NUM_OF_WORDS(NW[g])) u_dut (
            .clk          (clk),
            .reset        (rst_v[g]),
            .start        (start_v[g]),
            .message_addr (addr_v[g]),
            .mem_clk      (mem_clk_v[g]),
            .mem_we       (mem_we_v[g]),
            .mem_addr     (maddr_v[g]),
            .mem_read_data(rdata),
            .block_valid  (bv_v[g]),
            .block_ready  (brdy_v[g]),
            .block_data   (bd_v[g]),
            .block_last   (bl_v[g]),
            .done         (done_v[g])
        );
    end

    // Monitor: every presented block must match the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_v[i] && bv_v[i]) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_block inst=%0d got=%h", i, bd_v[i]);
                end else begin
                    if (exp_q[0].inst != i || bd_v[i] !== exp_q[0].data || bl_v[i] !== exp_q[0].last) begin
                        mismatched++;
                        $display("FAIL block inst=%0d got last=%0b data=%h expected last=%0b data=%h",
                                 i, bl_v[i], bd_v[i], exp_q[0].last, exp_q[0].data);
                    end
                    if (brdy_v[i]) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [511:0] got, input logic [511:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic load_seq(input logic [15:0] addr, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a      = addr + 16'(i);
            mem[a] = 32'(i + 1);
        end
    endtask

    task automatic load_rand(input logic [15:0] addr, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a      = addr + 16'(i);
            mem[a] = $urandom;
        end
    endtask

    // Reference: build the padded word stream, then cut it into 16-word blocks.
    task automatic push_expected(input int inst, input logic [15:0] addr, input int n);
        logic [31:0] stream [$];
        logic [63:0] bits;
        logic [15:0] a;
        exp_t        e;
        int          nb;
        for (int i = 0; i < n; i++) begin
            a = addr + 16'(i);
            stream.push_back(mem[a]);
        end
        stream.push_back(32'h8000_0000);
        while (stream.size() % 16 != 14) stream.push_back(32'd0);
        bits = 64'(n) * 64'd32;
        stream.push_back(bits[63:32]);
        stream.push_back(bits[31:0]);
        nb = stream.size() / 16;
        for (int b = 0; b < nb; b++) begin
            e.inst = inst;
            e.last = (b == nb - 1);
            e.data = 512'd0;
            for (int j = 0; j < 16; j++) e.data[511 - 32*j -: 32] = stream[16*b + j];
            exp_q.push_back(e);
        end
    endtask

    // mode 0: ready always high, 1: random ready, 2: 10-cycle stall with start pulses.
    task automatic run_msg(input int inst, input logic [15:0] addr, input int mode);
        int n;
        int cyc;
        bit seen;
        n = NW[inst];
        push_expected(inst, addr, n);
        addr_v[inst] = addr;
        brdy_v[inst] = (mode == 0) ? 1'b1 : 1'b0;
        tick();
        start_v[inst] = 1'b1;
        tick();
        start_v[inst] = 1'b0;
        cyc = 0;
        while (!bv_v[inst] && cyc < 100) begin
            tick();
            cyc++;
        end
        check_val("first_block_latency", cyc, ((n < 16) ? n : 16) + 2);
        if (mode == 2) begin
            for (int k = 1; k <= 10; k++) begin
                tick();
                start_v[inst] = (k == 3 || k == 6);
                check_val("stall_valid", int'(bv_v[inst]), 1);
                if (exp_q.size() > 0) check_vec("stall_data", bd_v[inst], exp_q[0].data);
            end
            start_v[inst] = 1'b0;
            brdy_v[inst]  = 1'b1;
        end
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 2000 && !seen) begin
            if (done_v[inst]) begin
                seen = 1'b1;
            end else begin
                brdy_v[inst] = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                tick();
                cyc++;
            end
        end
        check_val("done_seen", int'(seen), 1);
        check_val("queue_drained", exp_q.size(), 0);
        if (!seen) exp_q.delete();
        brdy_v[inst] = 1'b0;
        tick();
        check_val("done_one_cycle", int'(done_v[inst]), 0);
        check_val("idle_no_valid", int'(bv_v[inst]), 0);
    endtask

    task automatic check_reset_outputs(input int inst);
        check_val("rst_valid", int'(bv_v[inst]), 0);
        check_val("rst_last", int'(bl_v[inst]), 0);
        check_val("rst_done", int'(done_v[inst]), 0);
        check_vec("rst_data", bd_v[inst], 512'd0);
        check_val("rst_mem_addr", int'(maddr_v[inst]), 0);
        check_val("mem_we", int'(mem_we_v[inst]), 0);
    endtask

    task automatic reset_abort(input int inst);
        load_seq(16'h0000, NW[inst]);
        addr_v[inst] = 16'h0000;
        brdy_v[inst] = 1'b1;
        tick();
        start_v[inst] = 1'b1;
        tick();
        start_v[inst] = 1'b0;
        repeat (5) tick();
        rst_v[inst] = 1'b1;
        tick();
        check_reset_outputs(inst);
        rst_v[inst] = 1'b0;
        tick();
    endtask

    initial begin
        logic [15:0] a;
        rst_v   = '1;
        start_v = '0;
        brdy_v  = '0;
        addr_v  = '0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        repeat (3) tick();
        for (int i = 0; i < NI; i++) check_reset_outputs(i);
        rst_v = '0;
        tick();

        load_seq(16'h0000, 20);
        run_msg(0, 16'h0000, 0);
        repeat (3) begin
            a = 16'($urandom);
            load_rand(a, 20);
            run_msg(0, a, 1);
        end
        a = 16'($urandom);
        load_rand(a, 20);
        run_msg(0, a, 2);
        reset_abort(0);
        load_seq(16'h0000, 20);
        run_msg(0, 16'h0000, 0);

        for (int i = 1; i < NI; i++) begin
            a = (i == 3) ? 16'hFFFE : 16'h0000;
            load_seq(a, NW[i]);
            run_msg(i, a, 0);
            a = 16'($urandom);
            load_rand(a, NW[i]);
            run_msg(i, a, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
